// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage
//   Fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
//   It holds the PC, forms PC+4, redirects to a taken branch target and
//   registers the fetched instruction into Decode. The hazard unit can hold
//   both the PC and IF/ID. A taken branch in Decode squashes IF/ID.
//
//   Optional feature macro: FETCH_PERF_CNT_EN
//     defined   : saturating stall/flush/fetch performance counters
//     undefined : counters omitted, count outputs tied to 0
//
//   Ports
//     clk        in   rising-edge clock
//     reset      in   synchronous, active-high reset
//     StallF     in   hold PC
//     StallD     in   hold IF/ID register
//     PCSrcD     in   branch taken in Decode (redirect PC, squash IF/ID)
//     PCBranchD  in   branch target (bits [1:0] ignored)
//     InstrF     in   instruction memory data for PCF
//     PCF        out  current fetch address
//     InstrD     out  registered instruction
//     PCPlus4D   out  registered PC+4
//     ValidD     out  InstrD is a real instruction (0 = bubble)
//     StallCnt   out  cycles with StallF=1
//     FlushCnt   out  IF/ID flushes applied
//     FetchCnt   out  valid instructions loaded into IF/ID
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             PCSrcD,
  input  logic [31:0]      PCBranchD,
  input  logic [31:0]      InstrF,
  output logic [31:0]      PCF,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] FetchCnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic        flush;
  logic        load;

  assign pc_plus4 = pc_q + 32'd4;
  // A flush only takes effect when IF/ID is not being held.
  assign flush    = PCSrcD & ~StallD;
  assign load     = ~StallD & ~PCSrcD;

  always_comb begin
    pc_d = pc_q;
    if (!StallF) begin
      if (PCSrcD) pc_d = PCBranchD & 32'hFFFF_FFFC;
      else        pc_d = pc_plus4;
    end
  end

  always_comb begin
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = 32'h0000_0000;  // sll $0,$0,0 == nop
      pcp4_d  = 32'h0000_0000;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = InstrF;
      pcp4_d  = pc_plus4;
      valid_d = 1'b1;
    end
  end

  // Fetch -> Decode boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      pcp4_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign PCF      = pc_q;
  assign InstrD   = instr_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    stall_cnt_d = StallF ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d = flush  ? sat_inc(flush_cnt_q) : flush_cnt_q;
    fetch_cnt_d = load   ? sat_inc(fetch_cnt_q) : fetch_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      fetch_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
  assign FetchCnt = fetch_cnt_q;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
  assign FetchCnt = '0;
`endif

endmodule

// File: doc/fetch_decode_stage.md
# fetch_decode_stage

Fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline. Holds the program counter, computes PC+4, selects the branch target, and registers the fetched instruction into Decode. Directly consumes the hazard unit's StallF/StallD and the Decode-stage branch decision PCSrcD. Produces InstrD/PCPlus4D for the Decode stage and register file.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- CNT_W, 32, width of performance counters

- clk  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-high
- StallF  input  1  hold PC (from hazard unit)
- StallD  input  1  hold IF/ID register (from hazard unit)
- PCSrcD  input  1  branch taken in Decode; redirect PC, squash IF/ID
- PCBranchD  input  32  branch target from Decode
- InstrF  input  32  instruction memory read data for PCF (combinational memory)
- PCF  output  32  current fetch address to instruction memory
- InstrD  output  32  registered instruction for Decode
- PCPlus4D  output  32  registered PC+4 for Decode
- ValidD  output  1  InstrD holds a real fetched instruction (0 = bubble)
- StallCnt  output  CNT_W  cycles with StallF=1
- FlushCnt  output  CNT_W  IF/ID flushes applied
- FetchCnt  output  CNT_W  valid instructions loaded into IF/ID

## Operation
- PCPlus4F = PCF + 4, 32-bit modulo (0xFFFF_FFFC wraps to 0x0000_0000).
- PC register, per clock edge, priority order:
  - reset: PCF <= RESET_PC
  - StallF: PCF holds (StallF overrides PCSrcD)
  - PCSrcD: PCF <= {PCBranchD[31:2], 2'b00}
  - else: PCF <= PCPlus4F
- IF/ID register, per clock edge, priority order:
  - reset: InstrD<=0, PCPlus4D<=0, ValidD<=0
  - StallD: all three hold (StallD overrides flush)
  - PCSrcD: flush; InstrD<=0 (sll $0 = nop), PCPlus4D<=0, ValidD<=0
  - else: InstrD<=InstrF, PCPlus4D<=PCPlus4F, ValidD<=1
- PCBranchD[1:0] ignored; PCF[1:0] always 0.
- StallF=1 with StallD=0 is not produced by the hazard unit; if it occurs, IF/ID loads the same instruction again (no protection required).
- No internal state beyond PC, IF/ID register and counters; no FSM.

## Timing
- Fetch-to-decode latency: 1 cycle (InstrF sampled at edge, visible as InstrD after it).
- Taken-branch redirect: PCSrcD asserted in cycle N -> PCF = target in cycle N+1; instruction fetched in cycle N (delay slot) squashed, ValidD=0 in N+1.
- Stall: StallF/StallD high in cycle N -> PCF, InstrD, PCPlus4D, ValidD identical in N+1 to N.
- Reset mid-operation: all outputs return to reset values on the next edge regardless of StallF/StallD/PCSrcD; counters cleared.
- Reset values: PCF=RESET_PC, InstrD=0, PCPlus4D=0, ValidD=0, StallCnt=FlushCnt=FetchCnt=0.

## Configuration
- FETCH_PERF_CNT_EN defined: StallCnt increments each non-reset cycle StallF=1; FlushCnt increments each edge a flush is applied (PCSrcD=1, StallD=0); FetchCnt increments each edge IF/ID loads with ValidD<=1. All saturate at 2^CNT_W-1, clear only on reset.
- Not defined: counter logic omitted; StallCnt, FlushCnt, FetchCnt tied to 0; ports remain.

## Test plan
- Reset with RESET_PC=0x0040_0000, then 3 free cycles, InstrF=0x2008_0005 -> PCF 0x0040_0000,04,08,0C; InstrD=0x2008_0005, PCPlus4D=0x0040_0004 after first edge, ValidD=1.
- PCSrcD=1, PCBranchD=0x0040_0103, StallF=StallD=0 at PCF=0x0040_0008 -> next PCF=0x0040_0100, InstrD=0, PCPlus4D=0, ValidD=0; FlushCnt=1 (macro on).
- StallF=StallD=1 for 2 cycles at PCF=0x0040_0010 -> PCF and InstrD unchanged for 2 cycles, then PCF=0x0040_0014; StallCnt=2.
- StallF=StallD=1 together with PCSrcD=1 -> no redirect, no flush; PCF, InstrD, ValidD hold; FlushCnt unchanged.
- PCF=0xFFFF_FFFC, no stall/branch -> PCF=0x0000_0000, PCPlus4D=0x0000_0000; reset asserted during a stall -> PCF=RESET_PC, ValidD=0, counters 0 next edge.
- Build without FETCH_PERF_CNT_EN, repeat stall/flush scenario -> all counters read 0, datapath behaviour identical.
